// File: rtl/mac.sv
// -----------------------------------------------------------------------------
// mac -- three-stage pipelined signed multiply-accumulate.
//
//   p = a*b + c, with a latency of three ce-enabled rising edges and
//   one operand set accepted per ce-enabled edge.
//
//   Stage 1 : registers a, b, c (and acc_load when accumulation is built in)
//   Stage 2 : registers the full-precision signed product a*b and delayed c
//   Stage 3 : registers p
//
// Optional feature macro: MAC_ACCUM_EN
//   When defined, stage 3 accumulates p + product + c, saturating to the
//   2*WIDTH signed range. acc_load (delayed alongside the operands) makes
//   stage 3 restart from product + c instead of adding to the old p.
//   When undefined, the acc_load port and all accumulate/saturate logic
//   are absent.
//
// Parameters
//   WIDTH    operand width in bits, 2..32 (default 8)
//
// Ports
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset, clears all stages
//   ce       in   1        clock enable for every pipeline register
//   a        in   WIDTH    signed multiplicand
//   b        in   WIDTH    signed multiplier
//   c        in   WIDTH    signed addend
//   acc_load in   1        accumulator restart (MAC_ACCUM_EN builds only)
//   p        out  2*WIDTH  signed result, straight from the stage-3 register
// -----------------------------------------------------------------------------
module mac #(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ce,
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   input  logic signed [WIDTH-1:0]   c,
`ifdef MAC_ACCUM_EN
   input  logic                      acc_load,
`endif
   output logic signed [2*WIDTH-1:0] p
);

   localparam int PW = 2 * WIDTH;

   // Stage 1 registers
   logic signed [WIDTH-1:0] a_s1;
   logic signed [WIDTH-1:0] b_s1;
   logic signed [WIDTH-1:0] c_s1;

   // Stage 2 registers
   logic signed [PW-1:0]    prod_s2;
   logic signed [WIDTH-1:0] c_s2;

   // Size casts of signed values sign-extend, so the product is formed at
   // the full 2*WIDTH precision.
   logic signed [PW-1:0] prod_full;
   logic signed [PW-1:0] c_ext;

   assign prod_full = PW'(a_s1) * PW'(b_s1);
   assign c_ext     = PW'(c_s2);

   // Next value of p
   logic signed [PW-1:0] p_next;

`ifdef MAC_ACCUM_EN
   // Two guard bits: the sum of three PW-bit signed terms fits in PW+2 bits.
   localparam int EW = PW + 2;

   logic                 ld_s1;
   logic                 ld_s2;
   logic signed [EW-1:0] acc_base;
   logic signed [EW-1:0] acc_sum;

   always_comb begin
      acc_base = ld_s2 ? '0 : EW'(p);
      acc_sum  = acc_base + EW'(prod_s2) + EW'(c_ext);
      p_next   = acc_sum[PW-1:0];
      // The sum fits in PW bits only when the top three bits agree.
      if (acc_sum[EW-1:PW-1] != {3{acc_sum[EW-1]}}) begin
         if (acc_sum[EW-1]) p_next = {1'b1, {(PW-1){1'b0}}};
         else               p_next = {1'b0, {(PW-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_s1 <= 1'b0;
         ld_s2 <= 1'b0;
      end else if (ce) begin
         ld_s1 <= acc_load;
         ld_s2 <= ld_s1;
      end
   end
`else
   // Operand ranges guarantee a*b + c fits in 2*WIDTH bits.
   assign p_next = prod_s2 + c_ext;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_s1    <= '0;
         b_s1    <= '0;
         c_s1    <= '0;
         prod_s2 <= '0;
         c_s2    <= '0;
         p       <= '0;
      end else if (ce) begin
         a_s1    <= a;
         b_s1    <= b;
         c_s1    <= c;
         prod_s2 <= prod_full;
         c_s2    <= c_s1;
         p       <= p_next;
      end
   end

endmodule

// File: tb/tb_mac.sv
// -----------------------------------------------------------------------------
// tb_mac -- directed bench for mac (WIDTH = 8).
//
// Hand-computed results are pushed onto exp_q as each operand set is issued;
// the pipeline is preloaded with two zero results after every reset so that
// each ce-enabled edge pops the value that must appear on p at that edge.
// With MAC_ACCUM_EN defined the main sequence holds acc_load=1, which makes
// every result a fresh product + c; accumulation and saturation are then
// exercised separately at the end.
// -----------------------------------------------------------------------------
module tb_mac;

   localparam int W  = 16;
   localparam int OW = 8;

   logic                 clk;
   logic                 rst_n;
   logic                 ce;
   logic signed [OW-1:0] a;
   logic signed [OW-1:0] b;
   logic signed [OW-1:0] c;
   logic signed [W-1:0]  p;
`ifdef MAC_ACCUM_EN
   logic                 acc_load;
`endif

   mac #(.WIDTH(OW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (ce),
      .a        (a),
      .b        (b),
      .c        (c),
`ifdef MAC_ACCUM_EN
      .acc_load (acc_load),
`endif
      .p        (p)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] hold_exp;
   int           n_checks;
   int           n_fail;

   task automatic check(input string tag, input logic [W-1:0] exp);
      n_checks++;
      assert (p === exp) else begin
         n_fail++;
         $error("FAIL %s: p=%0d expected %0d", tag, p, $signed(exp));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prime_pipe();
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
      hold_exp = '0;
   endtask

   // Drive one operand set with ce=1 and check the result leaving stage 3.
   task automatic issue(input int av, input int bv, input int cv,
                        input int ev, input string tag);
      a  = OW'(av);
      b  = OW'(bv);
      c  = OW'(cv);
      ce = 1'b1;
      exp_q.push_back(W'(ev));
      step();
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s: expected queue empty, p=%0d", tag, p);
      end else begin
         hold_exp = exp_q.pop_front();
         check(tag, hold_exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      ce       = 1'b0;
      a        = '0;
      b        = '0;
      c        = '0;
`ifdef MAC_ACCUM_EN
      acc_load = 1'b1;
`endif
      #3;
      check("reset_state", '0);

      // Clocking with ce=1 during reset keeps p at zero.
      a  = 8'sd15;
      b  = -8'sd3;
      c  = 8'sd3;
      ce = 1'b1;
      step();
      check("reset_hold_1", '0);
      step();
      check("reset_hold_2", '0);

      // Release away from the clock edge.
      #3;
      rst_n = 1'b1;
      prime_pipe();

      // 15 * -3 + 3 = -42 held: zeros for two edges, then -42 steadily.
      issue(15, -3, 3, -42, "basic_e1");
      issue(15, -3, 3, -42, "basic_e2");
      issue(15, -3, 3, -42, "basic_e3");
      issue(15, -3, 3, -42, "basic_e4");

      // Extremes: -128*-128+127 = 16511, -128*127-128 = -16384.
      issue(-128, -128, 127, 16511, "ext_pos_fill1");
      issue(-128, 127, -128, -16384, "ext_neg_fill2");
      issue(3, 4, 5, 17, "ext_pos");
      issue(-7, 9, -1, -64, "ext_neg");
      issue(100, -50, 20, -4980, "stream_a");

      // Pause for four edges with junk on the inputs: p must freeze.
      ce = 1'b0;
      a  = 8'sd77;
      b  = -8'sd99;
      c  = 8'sd55;
      step();
      check("pause_1", hold_exp);
      a  = -8'sd1;
      b  = 8'sd127;
      c  = -8'sd128;
      step();
      check("pause_2", hold_exp);
      a  = 8'sd42;
      step();
      check("pause_3", hold_exp);
      b  = 8'sd0;
      step();
      check("pause_4", hold_exp);

      // Resume: the in-flight results come out in order.
      issue(-1, -1, -1, 0, "resume_1");
      issue(127, 127, -128, 16001, "resume_2");
      issue(0, 0, 0, 0, "resume_3");
      issue(0, 0, 0, 0, "resume_4");
      issue(0, 0, 0, 0, "resume_5");

      // Reset with data in flight.
      issue(15, -3, 3, -42, "flight_1");
      issue(15, -3, 3, -42, "flight_2");
      issue(15, -3, 3, -42, "flight_3");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", '0);
      #2;
      rst_n = 1'b1;
      prime_pipe();
      issue(0, 0, 0, 0, "post_reset_1");
      issue(0, 0, 0, 0, "post_reset_2");
      issue(0, 0, 0, 0, "post_reset_3");
      issue(0, 0, 0, 0, "post_reset_4");

`ifdef MAC_ACCUM_EN
      // Accumulate -42 per edge after a single load.
      rst_n = 1'b0;
      #2;
      rst_n    = 1'b1;
      ce       = 1'b1;
      a        = 8'sd15;
      b        = -8'sd3;
      c        = 8'sd3;
      acc_load = 1'b1;
      step();
      check("acc_e1", '0);
      acc_load = 1'b0;
      step();
      check("acc_e2", '0);
      step();
      check("acc_e3", 16'hffd6);   // -42
      step();
      check("acc_e4", 16'hffac);   // -84
      step();
      check("acc_e5", 16'hff82);   // -126

      // Saturation at +32767.
      rst_n = 1'b0;
      #2;
      rst_n    = 1'b1;
      acc_load = 1'b0;
      a        = -8'sd128;
      b        = -8'sd128;
      c        = 8'sd127;
      step();
      check("sat_e1", '0);
      step();
      check("sat_e2", '0);
      step();
      check("sat_e3", 16'd16511);
      step();
      check("sat_e4", 16'd32767);
      step();
      check("sat_e5", 16'd32767);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
